uart_msg_decoder: RTL and testbench

Parametrised message decoder between the UART receiver and the bot control logic. It collects received bytes into a frame buffer until a terminator byte arrives, then decodes Fault (IFM) and Pick-Block (PBM) messages into fault pulses and a held pick request with block location. It adds overflow protection, malformed-frame reporting, a pick handshake and a valid-frame counter.

---
 rtl/uart_msg_decoder.sv | 199 +++++++++++++++++++
 tb/tb_uart_msg_decoder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uart_msg_decoder.sv
// uart_msg_decoder: collects UART bytes into a frame buffer up to a terminator,
// then decodes Fault (IFM) and Pick-Block (PBM) messages into fault pulses,
// a held pick request with block location, malformed-frame errors and a
// valid-frame counter.
module uart_msg_decoder #(
    parameter int          MAX_LEN     = 12,
    parameter int          NUM_LOC     = 4,
    parameter int          LOC_W       = 2,
    parameter int          FAULT_PULSE = 1,
    parameter logic [7:0]  TERM        = 8'h23
) (
    input  logic             clk_50M,
    input  logic             rst_n,
    input  logic [7:0]       rx_msg,
    input  logic             rx_complete,
    input  logic             pick_ack,
    output logic             EU_fault_flag,
    output logic             CU_fault_flag,
    output logic             RU_fault_flag,
    output logic             pick_block_flag,
    output logic [LOC_W-1:0] block_location,
    output logic             msg_error,
    output logic [7:0]       frame_count
);

    localparam int               IDX_W     = $clog2(MAX_LEN);
    localparam int               CNT_W     = $clog2(FAULT_PULSE + 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(MAX_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FAULT_PULSE);
    localparam logic [7:0]       DIGIT_MAX = 8'(8'h30 + NUM_LOC);

    typedef enum logic [1:0] {COLLECT, DISCARD, DECODE, PULSE} state_t;
    typedef enum logic [1:0] {UNIT_NONE, UNIT_E, UNIT_C, UNIT_R} unit_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [7:0]       frame_buf [MAX_LEN];
    logic             rx_prev;
    logic             byte_edge;
    logic             buf_wr, buf_clr;
    logic             disc_term;
    logic [CNT_W-1:0] pcnt;
    logic             first_pulse, pulse_end;

    // Decode results, evaluated in DECODE and held through PULSE.
    unit_t            unit_dec, unit_q;
    logic             pbm_dec, pbm_q, err_q;
    logic [LOC_W-1:0] loc_dec, loc_q;

    assign byte_edge   = rx_complete & ~rx_prev;
    assign first_pulse = (state == PULSE) && (pcnt == '0);
    assign pulse_end   = (state == PULSE) && (pcnt == CNT_LAST);

    // State and write-index register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Next-state logic and buffer write/clear controls.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        buf_wr    = 1'b0;
        buf_clr   = 1'b0;
        case (state)
            COLLECT: begin
                if (byte_edge) begin
                    buf_wr = 1'b1;
                    if (rx_msg == TERM) begin
                        state_nxt = DECODE;
                        idx_nxt   = '0;
                    end else if (idx == IDX_LAST) begin
                        state_nxt = DISCARD;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            DISCARD: begin
                if (disc_term) begin
                    state_nxt = COLLECT;
                    buf_clr   = 1'b1;
                end
            end
            DECODE: state_nxt = PULSE;
            PULSE: begin
                if (pcnt == CNT_LAST) begin
                    state_nxt = COLLECT;
                    buf_clr   = 1'b1;
                end
            end
            default: state_nxt = COLLECT;
        endcase
    end

    // Rising-edge history of rx_complete, tracked in every state so a held level never recaptures.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) rx_prev <= 1'b0;
        else        rx_prev <= rx_complete;
    end

    // Frame buffer: byte write in COLLECT, full clear when a frame is finished.
    // NOTE: this memory is reset because unwritten positions must read 0x00 in DECODE.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_LEN; i++) frame_buf[i] <= 8'h00;
        end else if (buf_clr) begin
            for (int i = 0; i < MAX_LEN; i++) frame_buf[i] <= 8'h00;
        end else if (buf_wr) begin
            frame_buf[idx] <= rx_msg;
        end
    end

    // Marks the closing terminator of an overflowed frame; error is reported one cycle later.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) disc_term <= 1'b0;
        else        disc_term <= (state == DISCARD) && !disc_term && byte_edge && (rx_msg == TERM);
    end

    // Message pattern matching on the buffered frame.
    always_comb begin
        unit_dec = UNIT_NONE;
        if ({frame_buf[0], frame_buf[1], frame_buf[2], frame_buf[3]} == "IFM-") begin
            case (frame_buf[4])
                "E":     unit_dec = UNIT_E;
                "C":     unit_dec = UNIT_C;
                "R":     unit_dec = UNIT_R;
                default: unit_dec = UNIT_NONE;
            endcase
        end
        pbm_dec = ({frame_buf[0], frame_buf[1], frame_buf[2], frame_buf[3],
                    frame_buf[4], frame_buf[5], frame_buf[6], frame_buf[7]} == "PBM-SU-B")
                  && (frame_buf[8] >= 8'h31) && (frame_buf[8] <= DIGIT_MAX);
        loc_dec = LOC_W'(frame_buf[8] - 8'h31);
    end

    // Latch the decode verdict at the end of DECODE.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            unit_q <= UNIT_NONE;
            pbm_q  <= 1'b0;
            err_q  <= 1'b0;
            loc_q  <= '0;
        end else if (state == DECODE) begin
            unit_q <= unit_dec;
            pbm_q  <= pbm_dec;
            err_q  <= (unit_dec == UNIT_NONE) && !pbm_dec;
            loc_q  <= loc_dec;
        end
    end

    // Fault-pulse length counter, running only in PULSE.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n)                                pcnt <= '0;
        else if (state == PULSE && !pulse_end)     pcnt <= pcnt + CNT_W'(1);
        else                                       pcnt <= '0;
    end

    // Output registers: fault pulses, pick handshake, error pulse and frame counter.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            EU_fault_flag   <= 1'b0;
            CU_fault_flag   <= 1'b0;
            RU_fault_flag   <= 1'b0;
            pick_block_flag <= 1'b0;
            block_location  <= '0;
            msg_error       <= 1'b0;
            frame_count     <= 8'd0;
        end else begin
            if (first_pulse) begin
                EU_fault_flag <= (unit_q == UNIT_E);
                CU_fault_flag <= (unit_q == UNIT_C);
                RU_fault_flag <= (unit_q == UNIT_R);
            end else if (pulse_end) begin
                EU_fault_flag <= 1'b0;
                CU_fault_flag <= 1'b0;
                RU_fault_flag <= 1'b0;
            end
            if (first_pulse && pbm_q) begin
                pick_block_flag <= 1'b1;
                block_location  <= loc_q;
            end else if (pick_ack) begin
                pick_block_flag <= 1'b0;
            end
            msg_error <= (first_pulse && err_q) || disc_term;
            if (first_pulse && !err_q) frame_count <= frame_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_uart_msg_decoder.sv
// Directed self-checking bench for uart_msg_decoder (default parameters).
// Inputs change and outputs are sampled on the falling edge of clk_50M.
module tb_uart_msg_decoder;

    logic       clk_50M = 1'b0;
    logic       rst_n;
    logic [7:0] rx_msg;
    logic       rx_complete;
    logic       pick_ack;
    logic       EU_fault_flag, CU_fault_flag, RU_fault_flag;
    logic       pick_block_flag;
    logic [1:0] block_location;
    logic       msg_error;
    logic [7:0] frame_count;

    int n_cmp = 0;
    int n_bad = 0;
    int eu_n, cu_n, ru_n, err_n;

    uart_msg_decoder dut (
        .clk_50M         (clk_50M),
        .rst_n           (rst_n),
        .rx_msg          (rx_msg),
        .rx_complete     (rx_complete),
        .pick_ack        (pick_ack),
        .EU_fault_flag   (EU_fault_flag),
        .CU_fault_flag   (CU_fault_flag),
        .RU_fault_flag   (RU_fault_flag),
        .pick_block_flag (pick_block_flag),
        .block_location  (block_location),
        .msg_error       (msg_error),
        .frame_count     (frame_count)
    );

    always #10 clk_50M = ~clk_50M;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One byte: rx_complete high for one cycle, then low for one cycle.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk_50M);
        rx_msg      = b;
        rx_complete = 1'b1;
        @(negedge clk_50M);
        rx_complete = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    // Count high samples of the pulse outputs over n cycles.
    task automatic run_window(input int n);
        eu_n = 0; cu_n = 0; ru_n = 0; err_n = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_50M);
            eu_n  += int'(EU_fault_flag);
            cu_n  += int'(CU_fault_flag);
            ru_n  += int'(RU_fault_flag);
            err_n += int'(msg_error);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".eu"},   EU_fault_flag,   0);
        check({tag, ".cu"},   CU_fault_flag,   0);
        check({tag, ".ru"},   RU_fault_flag,   0);
        check({tag, ".pick"}, pick_block_flag, 0);
        check({tag, ".loc"},  block_location,  0);
        check({tag, ".err"},  msg_error,       0);
        check({tag, ".cnt"},  frame_count,     0);
    endtask

    initial begin
        rst_n = 1'b0; rx_msg = 8'h00; rx_complete = 1'b0; pick_ack = 1'b0;
        repeat (2) @(negedge clk_50M);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk_50M);

        // IFM 'E': pulse exactly at edge N+2, one cycle long.
        send_str("IFM-EU-#");
        @(negedge clk_50M);
        check("ifm_e.n1_eu", EU_fault_flag, 0);
        @(negedge clk_50M);
        check("ifm_e.n2_eu", EU_fault_flag, 1);
        check("ifm_e.n2_cu", CU_fault_flag, 0);
        check("ifm_e.n2_ru", RU_fault_flag, 0);
        check("ifm_e.n2_err", msg_error, 0);
        check("ifm_e.cnt", frame_count, 1);
        @(negedge clk_50M);
        check("ifm_e.n3_eu", EU_fault_flag, 0);

        // PBM digit 3: flag held until pick_ack.
        send_str("PBM-SU-B3-#");
        @(negedge clk_50M);
        check("pbm3.n1_pick", pick_block_flag, 0);
        @(negedge clk_50M);
        check("pbm3.n2_pick", pick_block_flag, 1);
        check("pbm3.loc", block_location, 2);
        check("pbm3.cnt", frame_count, 2);
        repeat (3) @(negedge clk_50M);
        check("pbm3.hold", pick_block_flag, 1);
        pick_ack = 1'b1;
        @(negedge clk_50M);
        pick_ack = 1'b0;
        check("pbm3.acked", pick_block_flag, 0);
        check("pbm3.loc_kept", block_location, 2);

        // PBM digit 4 (upper bound) with pick_ack in the set cycle: set wins.
        send_str("PBM-SU-B4-#");
        @(negedge clk_50M);
        pick_ack = 1'b1;
        @(negedge clk_50M);
        pick_ack = 1'b0;
        check("pbm4.set_wins", pick_block_flag, 1);
        check("pbm4.loc", block_location, 3);
        check("pbm4.cnt", frame_count, 3);
        @(negedge clk_50M);
        check("pbm4.still", pick_block_flag, 1);

        // Overflow: 13 non-terminator bytes, then '#'.
        for (int i = 0; i < 13; i++) send_byte("A");
        send_byte("#");
        run_window(5);
        check("ovf.err_pulses", err_n, 1);
        check("ovf.fault_pulses", eu_n + cu_n + ru_n, 0);
        check("ovf.cnt", frame_count, 3);

        send_str("IFM-CU-#");
        run_window(5);
        check("ifm_c.cu_pulses", cu_n, 1);
        check("ifm_c.other", eu_n + ru_n + err_n, 0);
        check("ifm_c.cnt", frame_count, 4);

        // Terminator as byte MAX_LEN is still a normal frame.
        send_str("IFM-RU-abcd#");
        run_window(5);
        check("edge12.ru_pulses", ru_n, 1);
        check("edge12.err", err_n, 0);
        check("edge12.cnt", frame_count, 5);

        // Out-of-range digit: error, pick state untouched.
        send_str("PBM-SU-B5-#");
        run_window(5);
        check("pbm5.err", err_n, 1);
        check("pbm5.pick", pick_block_flag, 1);
        check("pbm5.loc", block_location, 3);
        check("pbm5.cnt", frame_count, 5);

        send_str("PBM-SU-B0-#");
        run_window(5);
        check("pbm0.err", err_n, 1);
        check("pbm0.loc", block_location, 3);

        // Held rx_complete with '#': one capture, one empty-frame error.
        @(negedge clk_50M);
        rx_msg = "#";
        rx_complete = 1'b1;
        err_n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_50M);
            err_n += int'(msg_error);
        end
        rx_complete = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_50M);
            err_n += int'(msg_error);
        end
        check("held.err", err_n, 1);
        check("held.cnt", frame_count, 5);

        // Reset mid-frame discards "PB".
        send_str("PB");
        @(negedge clk_50M);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_50M);
            check_all_zero($sformatf("rst%0d", i));
        end
        rst_n = 1'b1;
        send_str("M-SU-B1-#");
        run_window(5);
        check("post_rst.err", err_n, 1);
        check("post_rst.pick", pick_block_flag, 0);
        check("post_rst.cnt", frame_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
